// File: rtl/prog_loader.sv
// prog_loader: assembles chunk-stream words into instruction RAM and holds the CPU in reset until loaded (LOADER_CHECKSUM_EN adds a trailing checksum word)
module prog_loader #(
   parameter int INST_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int CHUNK_WIDTH = 8,
   parameter int NUM_WORDS   = 256,
   parameter int RST_HOLD    = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [CHUNK_WIDTH-1:0] Chunk_In,
   input  logic                   Chunk_Valid,
   output logic                   Chunk_Ready,
   output logic                   Ram_Inst_Write,
   output logic [ADDR_WIDTH-1:0]  Inst_Addr,
   output logic [INST_WIDTH-1:0]  Ram_Inst_In,
   output logic                   Cpu_Reset,
   output logic                   Busy,
   output logic                   Done,
   output logic                   Error
);
   localparam int CPW = INST_WIDTH / CHUNK_WIDTH;
   localparam int CW = $clog2(CPW + 1);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, CHECK, HOLD, RUN, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, HOLD, RUN} state_t;
`endif
   state_t state;
   logic [CW-1:0] cnt;
   logic [HW-1:0] hold_cnt;
   logic [INST_WIDTH-1:0] shifted;
   logic take;
   logic last_chunk;
   assign take = Chunk_Valid && Chunk_Ready;
   assign last_chunk = cnt == CW'(CPW - 1);
   assign shifted = (Ram_Inst_In << CHUNK_WIDTH) | INST_WIDTH'(Chunk_In);
`ifdef LOADER_CHECKSUM_EN
   logic [INST_WIDTH-1:0] acc;
   logic [INST_WIDTH-1:0] sum;
   assign sum = shifted + acc;
`else
   assign Error = 1'b0;
`endif
   // Output flags are loaded together with the state they belong to: {ready, write, cpu_reset, busy, done}
   function automatic logic [4:0] flags(input state_t s);
      logic rdy;
`ifdef LOADER_CHECKSUM_EN
      rdy = s == ASSEMBLE || s == CHECK;
`else
      rdy = s == ASSEMBLE;
`endif
      return {rdy, s == WRITE, s != RUN, rdy || s == WRITE || s == HOLD, s == RUN};
   endfunction
   // Load sequencer: state, word assembly, address, hold timer and registered outputs advance together
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(IDLE);
         Inst_Addr <= '0;
         Ram_Inst_In <= '0;
         cnt <= '0;
         hold_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
         acc <= '0;
         Error <= 1'b0;
`endif
      end else begin
         case (state)
            ASSEMBLE: if (take) begin
               Ram_Inst_In <= shifted;
               cnt <= last_chunk ? '0 : cnt + 1'b1;
               if (last_chunk) begin
                  state <= WRITE;
                  {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(WRITE);
               end
            end
            WRITE: begin
`ifdef LOADER_CHECKSUM_EN
               acc <= acc + Ram_Inst_In;
`endif
               hold_cnt <= '0;
               if (Inst_Addr == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CHECK;
                  {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(CHECK);
`else
                  state <= HOLD;
                  {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(HOLD);
`endif
               end else begin
                  Inst_Addr <= Inst_Addr + 1'b1;
                  state <= ASSEMBLE;
                  {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(ASSEMBLE);
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (take) begin
               Ram_Inst_In <= shifted;
               cnt <= last_chunk ? '0 : cnt + 1'b1;
               if (last_chunk) begin
                  Error <= sum != '0;
                  if (sum == '0) begin
                     state <= HOLD;
                     {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(HOLD);
                  end else begin
                     state <= ERROR;
                     {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(ERROR);
                  end
               end
            end
`endif
            HOLD: if (hold_cnt == HW'(RST_HOLD - 1)) begin
               state <= RUN;
               {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(RUN);
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
            default: if (Start) begin
               state <= ASSEMBLE;
               {Chunk_Ready, Ram_Inst_Write, Cpu_Reset, Busy, Done} <= flags(ASSEMBLE);
               Inst_Addr <= '0;
               cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
               acc <= '0;
               Error <= 1'b0;
`endif
            end
         endcase
      end
   end
endmodule
